// File: rtl/aig_bench_sequencer.sv
// aig_bench_sequencer: drives counter/LFSR vectors into a benchmark netlist, MISR-compacts outputs, checks duplicate outputs
module aig_bench_sequencer #(
  parameter int IN_W   = 29,
  parameter int OUT_W  = 21,
  parameter int SIG_W  = 32,
  parameter int CNT_W  = 32,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] num_patterns,
  output logic [IN_W-1:0]  x_o,
  input  logic [OUT_W-1:0] f_i,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] patterns_done,
  output logic             dup_mismatch,
  output logic [IN_W-1:0]  first_mismatch_vec
);
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CAPTURE, DONE} state_t;
  state_t state, state_n;
  logic             mode_q;
  logic [IN_W-1:0]  vec;
  logic [CNT_W-1:0] n_q;
  logic [7:0]       wcnt;
  logic [CNT_W-1:0] pd_n;
  logic             f_dup_bad;
  assign pd_n = patterns_done + CNT_W'(1);
  assign f_dup_bad = (f_i != '0) && !(&f_i);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE    ? (start ? (num_patterns == '0 ? DONE : APPLY) : IDLE) :
              state == APPLY   ? (SETTLE > 0 ? WAIT : CAPTURE) :
              state == WAIT    ? (wcnt == 8'(SETTLE - 1) ? CAPTURE : WAIT) :
              state == CAPTURE ? (pd_n == n_q ? DONE : APPLY) :
              IDLE;
  end
  always_comb begin
    busy = state == APPLY || state == WAIT || state == CAPTURE;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_o <= '0;
      signature <= '0;
      patterns_done <= '0;
      dup_mismatch <= 1'b0;
      first_mismatch_vec <= '0;
      mode_q <= 1'b0;
      vec <= '0;
      n_q <= '0;
      wcnt <= '0;
    end else if (state == IDLE && start) begin
      mode_q <= mode;
      vec <= (mode && seed == '0) ? IN_W'(1) : seed;
      n_q <= num_patterns;
      signature <= '0;
      patterns_done <= '0;
      dup_mismatch <= 1'b0;
      first_mismatch_vec <= '0;
    end else if (state == APPLY) begin
      x_o <= vec;
      wcnt <= '0;
    end else if (state == WAIT) begin
      wcnt <= wcnt + 8'd1;
    end else if (state == CAPTURE) begin
      signature <= {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? SIG_W'(32'h04C11DB7) : '0) ^ SIG_W'(f_i);
      patterns_done <= pd_n;
      if (f_dup_bad && !dup_mismatch) begin
        dup_mismatch <= 1'b1;
        first_mismatch_vec <= x_o;
      end
      vec <= mode_q ? {x_o[IN_W-2:0], x_o[IN_W-1] ^ x_o[IN_W-3]} : x_o + IN_W'(1);
    end
  end
endmodule

// File: tb/tb_aig_bench_sequencer.sv
// tb_aig_bench_sequencer: directed checks of vector generation, MISR, duplicate check, timing and reset
module tb_aig_bench_sequencer;
  localparam int P = 4;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [28:0] seed = '0;
  logic [31:0] num_patterns = '0;
  logic [28:0] x_o;
  logic [20:0] f_i, f_const = '0;
  logic        f_dep = 1'b0;
  logic        busy, done, dup_mismatch;
  logic [31:0] signature, patterns_done;
  logic [28:0] first_mismatch_vec;
  logic [28:0] xs [16];
  logic [31:0] sigs [16];
  int cmp = 0, bad = 0, cyc = 0;
  logic saw_done;

  aig_bench_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .num_patterns(num_patterns), .x_o(x_o), .f_i(f_i), .busy(busy), .done(done),
    .signature(signature), .patterns_done(patterns_done),
    .dup_mismatch(dup_mismatch), .first_mismatch_vec(first_mismatch_vec)
  );

  always #5 clk = ~clk;
  always_comb f_i = f_dep ? ((x_o == 29'h12) ? 21'h1 : 21'h0) : f_const;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic m, input logic [28:0] s, input logic [31:0] n);
    @(negedge clk);
    mode = m; seed = s; num_patterns = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    forever begin
      if (cyc >= 3 && (cyc - 3) % P == 0 && (cyc - 3) / P < 16) xs[(cyc - 3) / P] = x_o;
      if (cyc >= 5 && (cyc - 5) % P == 0 && (cyc - 5) / P < 16) sigs[(cyc - 5) / P] = signature;
      if (done || cyc >= 200) break;
      @(negedge clk);
      cyc++;
    end
    chk("no_timeout", 64'(cyc < 200), 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_x_o", 64'(x_o), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_sig", 64'(signature), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'h0);
    chk("idle_done", 64'(done), 64'h0);

    f_const = 21'h1FFFFF;
    run(1'b0, 29'h0, 32'd2);
    chk("t1_latency", 64'(cyc), 64'd9);
    chk("t1_x0", 64'(xs[0]), 64'h0);
    chk("t1_x1", 64'(xs[1]), 64'h1);
    chk("t1_sig0", 64'(sigs[0]), 64'h001FFFFF);
    chk("t1_sig1", 64'(sigs[1]), 64'h00200001);
    chk("t1_pd", 64'(patterns_done), 64'd2);
    chk("t1_dup", 64'(dup_mismatch), 64'h0);
    chk("t1_busy_in_done", 64'(busy), 64'h0);
    @(negedge clk);
    chk("t1_done_one_cycle", 64'(done), 64'h0);
    chk("t1_sig_hold", 64'(signature), 64'h00200001);

    f_const = 21'h0;
    run(1'b0, 29'h1FFFFFFF, 32'd2);
    chk("t2_x0", 64'(xs[0]), 64'h1FFFFFFF);
    chk("t2_x1", 64'(xs[1]), 64'h0);
    chk("t2_x_final", 64'(x_o), 64'h0);

    run(1'b1, 29'h0, 32'd3);
    chk("t3_x0", 64'(xs[0]), 64'h1);
    chk("t3_x1", 64'(xs[1]), 64'h2);
    chk("t3_x2", 64'(xs[2]), 64'h4);
    chk("t3_pd", 64'(patterns_done), 64'd3);
    chk("t3_latency", 64'(cyc), 64'd13);

    f_dep = 1'b1;
    run(1'b0, 29'h10, 32'd4);
    chk("t4_dup", 64'(dup_mismatch), 64'h1);
    chk("t4_first_vec", 64'(first_mismatch_vec), 64'h12);
    chk("t4_sig", 64'(signature), 64'h2);
    chk("t4_x_final", 64'(x_o), 64'h13);
    @(negedge clk);
    chk("t4_dup_sticky", 64'(dup_mismatch), 64'h1);
    f_dep = 1'b0;

    run(1'b0, 29'h55, 32'd0);
    chk("t5_latency", 64'(cyc), 64'd1);
    chk("t5_sig", 64'(signature), 64'h0);
    chk("t5_pd", 64'(patterns_done), 64'h0);
    chk("t5_x_hold", 64'(x_o), 64'h13);
    chk("t5_dup_cleared", 64'(dup_mismatch), 64'h0);

    f_const = 21'h1FFFFF;
    @(negedge clk);
    mode = 1'b0; seed = 29'h5; num_patterns = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    @(negedge clk);
    num_patterns = 32'd0; seed = 29'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy_start_ignored", 64'(patterns_done), 64'd1);
    chk("t6_busy", 64'(busy), 64'h1);
    @(negedge clk);
    chk("t6_x_second", 64'(x_o), 64'h6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_x", 64'(x_o), 64'h0);
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_sig", 64'(signature), 64'h0);
    chk("t6_rst_pd", 64'(patterns_done), 64'h0);
    chk("t6_rst_dup", 64'(dup_mismatch), 64'h0);
    chk("t6_rst_fmv", 64'(first_mismatch_vec), 64'h0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    chk("t6_idle_after_rst", 64'(saw_done), 64'h0);
    chk("t6_sig_idle", 64'(signature), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
